// File: rtl/video_sig_gen.sv
// video_sig_gen: free-running raster timing generator.
//
// Produces the pixel position (hcount_out, vcount_out) of a video raster
// together with sync, active-draw, new-frame and frame-count signals.
// Every output comes straight from a flop. All outputs are computed from the
// same next position, so the flags always describe the coordinates shown in
// the same cycle.
//
// Ports:
//   clk_in      in   1   pixel clock, rising-edge
//   rst_in      in   1   synchronous active-high reset
//   hcount_out  out  11  pixel column within line
//   vcount_out  out  10  line within frame
//   hs_out      out  1   horizontal sync, active low
//   vs_out      out  1   vertical sync, active low
//   ad_out      out  1   active draw (inside visible area)
//   nf_out      out  1   one-cycle new-frame pulse at (H_ACTIVE, V_ACTIVE)
//   fc_out      out  6   frame count modulo FPS
module video_sig_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter int FPS      = 60
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        ad_out,
    output logic        nf_out,
    output logic [5:0]  fc_out
);

    localparam logic [10:0] H_LAST       = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] H_ACT        = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT        = 10'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [5:0]  FC_LAST      = 6'(FPS - 1);

    // Low while in reset. The first edge after release presents (0,0) once
    // instead of advancing, so the raster always starts at the origin.
    logic        run_r;

    logic [10:0] h_next_s;
    logic [9:0]  v_next_s;
    logic        hs_next_s;
    logic        vs_next_s;
    logic        ad_next_s;
    logic        nf_next_s;
    logic [5:0]  fc_next_s;

    // Next raster position and the flags that belong to that position.
    always_comb begin
        h_next_s = hcount_out;
        v_next_s = vcount_out;
        if (!run_r) begin
            h_next_s = 11'd0;
            v_next_s = 10'd0;
        end else if (hcount_out == H_LAST) begin
            h_next_s = 11'd0;
            if (vcount_out == V_LAST) begin
                v_next_s = 10'd0;
            end else begin
                v_next_s = vcount_out + 10'd1;
            end
        end else begin
            h_next_s = hcount_out + 11'd1;
        end

        hs_next_s = !((h_next_s >= H_SYNC_START) && (h_next_s <= H_SYNC_END));
        vs_next_s = !((v_next_s >= V_SYNC_START) && (v_next_s <= V_SYNC_END));
        ad_next_s = (h_next_s < H_ACT) && (v_next_s < V_ACT);
        nf_next_s = (h_next_s == H_ACT) && (v_next_s == V_ACT);

        fc_next_s = fc_out;
        if (nf_next_s) begin
            if (fc_out == FC_LAST) begin
                fc_next_s = 6'd0;
            end else begin
                fc_next_s = fc_out + 6'd1;
            end
        end else begin
            fc_next_s = fc_out;
        end
    end

    // Output registers; reset overrides counting at any position.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            run_r      <= 1'b0;
            hcount_out <= 11'd0;
            vcount_out <= 10'd0;
            hs_out     <= 1'b1;
            vs_out     <= 1'b1;
            ad_out     <= 1'b0;
            nf_out     <= 1'b0;
            fc_out     <= 6'd0;
        end else begin
            run_r      <= 1'b1;
            hcount_out <= h_next_s;
            vcount_out <= v_next_s;
            hs_out     <= hs_next_s;
            vs_out     <= vs_next_s;
            ad_out     <= ad_next_s;
            nf_out     <= nf_next_s;
            fc_out     <= fc_next_s;
        end
    end

endmodule

// File: tb/tb_video_sig_gen.sv
// Testbench for video_sig_gen using a reduced raster so that many frames fit
// in a short run. A reference model pushes the expected output vector into a
// scoreboard queue each time a clock edge is driven; the vector is popped and
// compared after the edge. Directed checks cover reset, start-up, sync
// placement, boundaries, frame period, frame counting and mid-sync reset.
module tb_video_sig_gen;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 10, VF = 2, VS = 3, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 32
    localparam int VT = VA + VF + VS + VB;   // 18
    localparam int FRAME = HT * VT;          // 576
    localparam int FPS = 60;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        hs_out, vs_out, ad_out, nf_out;
    logic [5:0]  fc_out;

    int total = 0;
    int bad   = 0;

    video_sig_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .FPS(FPS)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hs_out(hs_out), .vs_out(vs_out), .ad_out(ad_out),
        .nf_out(nf_out), .fc_out(fc_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model state.
    int m_h = 0, m_v = 0, m_fc = 0;
    bit m_run = 1'b0;
    logic [30:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one clock edge with the given reset value and score the outputs.
    task automatic step(input logic r);
        logic [30:0] e;
        logic [30:0] o;
        bit hs_e, vs_e, ad_e, nf_e;
        rst_in = r;
        if (r) begin
            m_run = 1'b0; m_h = 0; m_v = 0; m_fc = 0;
            e = {11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
        end else begin
            if (!m_run) begin
                m_run = 1'b1; m_h = 0; m_v = 0;
            end else begin
                m_h = m_h + 1;
                if (m_h == HT) begin
                    m_h = 0;
                    m_v = (m_v + 1) % VT;
                end
            end
            hs_e = !(m_h >= HA + HF && m_h < HA + HF + HS);
            vs_e = !(m_v >= VA + VF && m_v < VA + VF + VS);
            ad_e = (m_h < HA) && (m_v < VA);
            nf_e = (m_h == HA) && (m_v == VA);
            if (nf_e) m_fc = (m_fc + 1) % FPS;
            e = {11'(m_h), 10'(m_v), hs_e, vs_e, ad_e, nf_e, 6'(m_fc)};
        end
        sb_q.push_back(e);
        @(posedge clk_in);
        #1;
        o = {hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out};
        check("scoreboard", 32'(o), 32'(sb_q.pop_front()));
    endtask

    initial begin
        int ad_line0;
        int hs_low;
        int last_nf;
        int nf_seen;
        int cyc;
        int ph, pv, pfc;
        logic phs, pvs;
        bit found;

        rst_in = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) step(1'b1);
        check("rst_h", 32'(hcount_out), 32'd0);
        check("rst_hs", 32'(hs_out), 32'd1);
        check("rst_vs", 32'(vs_out), 32'd1);
        check("rst_ad", 32'(ad_out), 32'd0);

        // Release: (0,0) with ad=1, then (1,0).
        step(1'b0);
        check("rel_pos", 32'({hcount_out, vcount_out}), 32'd0);
        check("rel_ad", 32'(ad_out), 32'd1);
        ad_line0 = 1;
        step(1'b0);
        check("rel_h1", 32'(hcount_out), 32'd1);
        check("rel_v1", 32'(vcount_out), 32'd0);
        ad_line0 += int'(ad_out);

        cyc = 1; last_nf = -1; nf_seen = 0; hs_low = 0;
        ph = int'(hcount_out); pv = int'(vcount_out); pfc = int'(fc_out);
        phs = hs_out; pvs = vs_out;
        // Run just over 61 frames of the reduced raster.
        for (int i = 0; i < 62 * FRAME; i++) begin
            step(1'b0);
            cyc++;
            if (cyc < HT) ad_line0 += int'(ad_out);
            if (cyc == HT) check("ad_line0", 32'(ad_line0), 32'(HA));
            if (!hs_out) hs_low++;
            if (hcount_out == 11'd0) begin
                if (cyc > HT) check("hs_width", 32'(hs_low), 32'(HS));
                hs_low = 0;
            end
            if (phs && !hs_out) check("hs_start", 32'(hcount_out), 32'(HA + HF));
            if (pvs && !vs_out) check("vs_start", 32'({hcount_out, vcount_out}), 32'({11'd0, 10'(VA + VF)}));
            if (!pvs && vs_out) check("vs_end", 32'({hcount_out, vcount_out}), 32'({11'd0, 10'(VA + VF + VS)}));
            if (ph == HT - 1 && pv == VT - 1) check("wrap", 32'({hcount_out, vcount_out}), 32'd0);
            if (hcount_out == 11'(HA - 1) && vcount_out == 10'(VA - 1)) check("ad_corner_in", 32'(ad_out), 32'd1);
            if (hcount_out == 11'(HA) && vcount_out == 10'(VA - 1)) check("ad_right", 32'(ad_out), 32'd0);
            if (hcount_out == 11'd0 && vcount_out == 10'(VA)) check("ad_below", 32'(ad_out), 32'd0);
            if (int'(fc_out) != pfc) check("fc_with_nf", 32'(nf_out), 32'd1);
            if (nf_out) begin
                nf_seen++;
                check("fc_seq", 32'(fc_out), 32'(nf_seen % FPS));
                if (last_nf >= 0) check("nf_period", 32'(cyc - last_nf), 32'(FRAME));
                last_nf = cyc;
            end
            ph = int'(hcount_out); pv = int'(vcount_out); pfc = int'(fc_out);
            phs = hs_out; pvs = vs_out;
        end
        check("nf_count", 32'(nf_seen >= 61), 32'd1);

        // Reset in the middle of both syncs.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (hcount_out == 11'(HA + HF + 1) && vcount_out == 10'(VA + VF + 1)) found = 1'b1;
            else step(1'b0);
        end
        check("reach_sync", 32'(found), 32'd1);
        step(1'b1);
        check("mid_rst_hs", 32'(hs_out), 32'd1);
        check("mid_rst_vs", 32'(vs_out), 32'd1);
        check("mid_rst_pos", 32'({hcount_out, vcount_out}), 32'd0);
        step(1'b0);
        check("restart_pos", 32'({hcount_out, vcount_out}), 32'd0);
        check("restart_fc", 32'(fc_out), 32'd0);
        check("restart_ad", 32'(ad_out), 32'd1);
        for (int i = 0; i < 2 * HT; i++) step(1'b0);
        check("restart_v", 32'(vcount_out), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_sig_gen.md
VIDEO_SIG_GEN -- requirements
Module: video_sig_gen

Interface
REQ-001 Parameter H_ACTIVE, 1024, visible pixels per line.
REQ-002 Parameter H_FP, 24, horizontal front porch cycles.
REQ-003 Parameter H_SYNC, 136, horizontal sync width cycles.
REQ-004 Parameter H_BP, 160, horizontal back porch cycles (line total 1344).
REQ-005 Parameter V_ACTIVE, 768, visible lines per frame.
REQ-006 Parameter V_FP, 3, vertical front porch lines.
REQ-007 Parameter V_SYNC, 6, vertical sync width lines.
REQ-008 Parameter V_BP, 29, vertical back porch lines (frame total 806).
REQ-009 Parameter FPS, 60, frame counter modulus.
REQ-010 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk_in and rst_in.
REQ-011 clk_in  input  1  pixel clock; all state updates on its rising edge.
REQ-012 rst_in  input  1  synchronous active-high reset.
REQ-013 hcount_out  output  11  pixel column within line, 0..1343.
REQ-014 vcount_out  output  10  line within frame, 0..805.
REQ-015 hs_out  output  1  horizontal sync, active low.
REQ-016 vs_out  output  1  vertical sync, active low.
REQ-017 ad_out  output  1  active draw: high when hcount_out < H_ACTIVE and vcount_out < V_ACTIVE.
REQ-018 nf_out  output  1  single-cycle new-frame pulse.
REQ-019 fc_out  output  6  frame count modulo FPS.

Function
REQ-020 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-021 hs_out, vs_out, ad_out and nf_out SHALL describe the position shown on hcount_out/vcount_out in the same cycle (zero relative skew), because downstream address generation pipelines from these values.
REQ-022 hcount_out SHALL increment by 1 per cycle and wrap from 1343 to 0.
REQ-023 On that wrap, vcount_out SHALL increment by 1, wrapping from 805 to 0.
REQ-024 hs_out SHALL be 0 exactly for hcount_out in [1048, 1183] on every line, including blank lines.
REQ-025 vs_out SHALL be 0 exactly for vcount_out in [771, 776], for all hcount_out values of those lines.
REQ-026 nf_out SHALL be 1 only in the cycle where hcount_out = 1024 and vcount_out = 768.
REQ-027 fc_out SHALL increment in the same cycle nf_out is 1 and wrap from FPS-1 to 0.
REQ-028 The sequence SHALL be free-running with no enable or stall; the frame period is exactly 1344*806 = 1083264 cycles.
REQ-029 Counter widths SHALL hold all values up to the totals with no overflow; comparisons are unsigned.
REQ-030 Region boundaries SHALL derive from the parameters (sync start = ACTIVE+FP; sync end = ACTIVE+FP+SYNC-1) and not be hard-coded.

Reset
REQ-031 While rst_in = 1 at a clock edge, outputs SHALL take: hcount_out=0, vcount_out=0, hs_out=1, vs_out=1, ad_out=0, nf_out=0, fc_out=0.
REQ-032 The first edge with rst_in = 0 SHALL present hcount_out=0, vcount_out=0, ad_out=1, i.e. position (0,0) held once, then normal counting.
REQ-033 rst_in asserted at any position (mid-line, mid-sync, during the nf_out cycle) SHALL override all counting on that edge and restart per REQ-032; no partial pulse SHALL follow release.

Verification
REQ-034 Reset 3 cycles, release -> cycle 1 after release (0,0) ad=1; cycle 2 (1,0); line 0 ad=1 for exactly 1024 cycles.
REQ-035 Run one full frame -> hs_out low 136 cycles per line starting at hcount 1048; vs_out low for lines 771..776; 1083264 cycles between successive nf_out pulses.
REQ-036 Check boundaries -> (1343,805) is followed by (0,0); (1023,767) ad=1; (1024,767) ad=0; (0,768) ad=0.
REQ-037 Run 61 frames -> fc_out sequence 1..59, 0, 1, with each change coincident with nf_out.
REQ-038 Assert rst_in for 1 cycle at (1100,772) -> next edge reset values with hs_out=vs_out=1; after release the sequence restarts at (0,0) with fc_out=0.
REQ-039 Scoreboard every cycle -> ad/hs/vs/nf are exactly consistent with hcount/vcount per REQ-017/024/025/026 (zero skew).
